// File: rtl/note_sequencer.sv
// Programmable note sequencer: DEPTH-entry (note, length) pattern memory
// stepped by note strobes, driving the PWM channel phase delta.
module note_sequencer #(
    parameter int DEPTH  = 16,
    parameter int NOTE_W = 6,
    parameter int LEN_W  = 5,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_note_stb,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_addr,
    input  logic [NOTE_W-1:0] i_wr_note,
    input  logic [LEN_W-1:0]  i_wr_len,
    input  logic [IDX_W-1:0]  i_last_index,
    input  logic              i_loop,
    input  logic              i_start,
    input  logic              i_stop,
    output logic [NOTE_W-1:0] o_note,
    output logic [IDX_W-1:0]  o_index,
    output logic              o_new_note,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_phase_delta
);

    typedef enum logic {S_IDLE, S_PLAY} state_t;

    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [LEN_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_new, w_new_nxt;
    logic                r_done, w_done_nxt;
    logic [NOTE_W-1:0]   r_note_mem [DEPTH];
    logic [LEN_W-1:0]    r_len_mem  [DEPTH];

    logic                w_end;
    logic                w_last;
    logic [NOTE_W-1:0]   w_note;

    // Equal-tempered deltas for octave 2 (C..B), 50 MHz, 32-bit accumulator
    function automatic logic [31:0] note_table(input logic [NOTE_W-1:0] n);
        logic [31:0] base;
        int unsigned k, semi, oct;
        if (n == '0) return '0;
        k    = 32'(n) - 1;
        semi = k % 12;
        oct  = k / 12;
        case (semi)
            0:       base = 32'd5619;
            1:       base = 32'd5953;
            2:       base = 32'd6307;
            3:       base = 32'd6681;
            4:       base = 32'd7079;
            5:       base = 32'd7500;
            6:       base = 32'd7946;
            7:       base = 32'd8418;
            8:       base = 32'd8919;
            9:       base = 32'd9449;
            10:      base = 32'd10011;
            default: base = 32'd10606;
        endcase
        return base << oct;
    endfunction

    assign w_end  = (r_cnt == r_len_mem[r_idx]);
    // A lowered last index still ends the pattern at the current entry
    assign w_last = (r_idx >= i_last_index);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_new_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        if (i_stop) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (i_start) begin
            w_state_nxt = S_PLAY;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            w_new_nxt   = 1'b1;
        end else if (i_note_stb && r_state == S_PLAY) begin
            if (!w_end) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end else if (!w_last) begin
                w_cnt_nxt = '0;
                w_idx_nxt = r_idx + 1'b1;
                w_new_nxt = 1'b1;
            end else if (i_loop) begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                w_new_nxt = 1'b1;
            end else begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_done_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_new   <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_note_mem[i] <= '0;
                r_len_mem[i]  <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_new   <= w_new_nxt;
            r_done  <= w_done_nxt;
            if (i_wr_en) begin
                r_note_mem[i_wr_addr] <= i_wr_note;
                r_len_mem[i_wr_addr]  <= i_wr_len;
            end
        end
    end

    assign w_note        = (r_state == S_PLAY) ? r_note_mem[r_idx] : '0;
    assign o_note        = w_note;
    assign o_index       = r_idx;
    assign o_new_note    = r_new;
    assign o_busy        = (r_state == S_PLAY);
    assign o_done        = r_done;
    assign o_phase_delta = note_table(w_note);

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Programmable, parametrised successor to the fixed channel note sequencers. It holds a DEPTH-entry pattern memory of (note, length) pairs that is written at run time. On start it steps through entries 0..i_last_index, advancing on note strobes, in loop or one-shot mode. It sits between the tick/note strobe generator and the PWM channel, and drives the channel's phase delta through `note_table`.

## Interface
Parameters:
- DEPTH, 16, number of pattern entries; must be a power of two, 2..256
- NOTE_W, 6, note code width; code 0 is rest (`NOTE_RST`)
- LEN_W, 5, length field width; an entry lasts len+1 note strobes
- IDX_W, $clog2(DEPTH), index width (derived; do not override)

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_note_stb  in  1  one-cycle note-duration strobe
- i_wr_en  in  1  pattern write enable
- i_wr_addr  in  IDX_W  pattern write address
- i_wr_note  in  NOTE_W  note code to write
- i_wr_len  in  LEN_W  length to write
- i_last_index  in  IDX_W  final entry of the pattern, sampled on every step
- i_loop  in  1  1 = wrap to entry 0 after last entry; 0 = stop
- i_start  in  1  one-cycle start/restart request
- i_stop  in  1  one-cycle stop request
- o_note  out  NOTE_W  current note code; 0 when idle
- o_index  out  IDX_W  current entry index
- o_new_note  out  1  one-cycle pulse: o_note/o_index show a newly entered entry
- o_busy  out  1  1 while in PLAY
- o_done  out  1  one-cycle pulse on one-shot completion
- o_phase_delta  out  32  `note_table` lookup of o_note

## Operation
- State machine has two states.
  - IDLE: o_note = 0; the duration counter and index are held.
  - PLAY: o_note = mem[index].note.
- Pattern memory is a register array. Reads are combinational. A write takes effect at the clock edge, so the new value is visible the next cycle, including for the entry now playing. Writes are accepted in any state.
- Request priority per cycle: i_stop > i_start > i_note_stb.
- i_stop: go to IDLE, clear count to 0, hold index. No o_done pulse.
- i_start from either state: go to PLAY, set index = 0 and count = 0, pulse o_new_note.
- i_note_stb in PLAY:
  - If count != mem[index].len: count + 1.
  - If count == len and index != i_last_index: count = 0, index + 1, pulse o_new_note.
  - If count == len, index == i_last_index, and i_loop = 1: count = 0, index = 0, pulse o_new_note.
  - If count == len, index == i_last_index, and i_loop = 0: go to IDLE, count = 0, index = 0, pulse o_done.
- i_note_stb in IDLE is ignored.
- If index > i_last_index (last index was lowered mid-play): the next end-of-entry wraps or finishes exactly as at i_last_index.
- Counter compare is equality over LEN_W bits. len = 0 lasts 1 strobe; len = 2^LEN_W − 1 lasts 2^LEN_W strobes.

## Timing
- Reset values:
  - state = IDLE, index = 0, count = 0
  - all memory entries = {note 0, len 0}
  - o_note = 0, o_index = 0, o_new_note = 0, o_busy = 0, o_done = 0
  - o_phase_delta = note_table(0)
- State, index, count, o_new_note and o_done are registered. o_note and o_phase_delta are combinational from the registered state, index and memory.
- Latency: a request or strobe sampled at edge N produces its o_note/o_index/o_busy change and its pulse during cycle N+1.
- Reset asserted mid-play returns all registers to reset values immediately (asynchronously). Deassertion is synchronised externally.
- Write and step to the same entry in one cycle: the step uses the old len; o_note shows the new note from the next cycle.

## Test plan
- After reset, write entries 0..2 = {5,1},{9,0},{12,2}, set last = 2, loop = 0, pulse start. Required: o_new_note with note 5. Two strobes move to note 9, one strobe to note 12, three strobes give o_done, busy 0, o_note 0.
- Same pattern with loop = 1. Required: after the 3rd strobe on entry 2, index wraps to 0, o_new_note pulses, note 5, busy stays 1, no o_done.
- During PLAY on entry 1, assert i_stop and i_note_stb together. Required: IDLE, o_note 0, index 1 held, no o_new_note.
- Assert i_start while on entry 2. Required: next cycle index 0, count 0, o_new_note. Also, i_start and i_stop together leave the block IDLE.
- DEPTH = 8, LEN_W = 3, entry 7 = {3,7}, last = 7, started at entry 7 via a looping pattern. Required: exactly 8 strobes, then wrap to 0.
- Assert i_rst_n low asynchronously mid-entry. Required: all outputs return to reset values without a clock edge, and the memory reads as zero.
